fifo_uart_tx: RTL and testbench

//  Downstream drain stage for the 32x8 sync FIFO: pops one byte at a time

---
 rtl/fifo_uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_uart_tx                                                  |
// | Brief    : FIFO drain stage; pops bytes and sends them as UART frames.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int                 c_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_PRE  = c_CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic               c_TWO_STOP = (STOP_BITS == 2);
    localparam logic               c_PAR_EN   = (PARITY_EN != 0);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_POP    = 3'd1;
    localparam logic [2:0] c_ST_LATCH  = 3'd2;
    localparam logic [2:0] c_ST_START  = 3'd3;
    localparam logic [2:0] c_ST_DATA   = 3'd4;
    localparam logic [2:0] c_ST_PARITY = 3'd5;
    localparam logic [2:0] c_ST_STOP   = 3'd6;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_baud;
    logic [2:0]         r_bit;
    logic               r_stop;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic               r_tx;
    logic               r_rd;
    logic               r_busy;
    logic               r_done;

    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_baud_nxt;
    logic [2:0]         w_bit_nxt;
    logic               w_stop_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_parity_nxt;
    logic               w_tx_nxt;
    logic               w_rd_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_baud_last;
    logic               w_last_stop;

    assign w_baud_last = (r_baud == c_CNT_LAST);
    assign w_last_stop = (r_stop == c_TWO_STOP);

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_stop   <= 1'b0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_rd     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_stop   <= w_stop_nxt;
            r_shift  <= w_shift_nxt;
            r_parity <= w_parity_nxt;
            r_tx     <= w_tx_nxt;
            r_rd     <= w_rd_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Outputs are registered from the next state, so each pin matches the state it belongs to.
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bit_nxt    = r_bit;
        w_stop_nxt   = r_stop;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_tx_nxt     = 1'b1;
        w_rd_nxt     = 1'b0;
        w_busy_nxt   = 1'b1;
        w_done_nxt   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_busy_nxt = 1'b0;
                if (en && !fifo_empty) begin
                    w_state_nxt = c_ST_POP;
                    w_rd_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end

            c_ST_POP: begin
                w_state_nxt = c_ST_LATCH;
            end

            c_ST_LATCH: begin
                w_shift_nxt  = fifo_data;
                w_parity_nxt = ^fifo_data;
                w_baud_nxt   = '0;
                w_state_nxt  = c_ST_START;
                w_tx_nxt     = 1'b0;
            end

            c_ST_START: begin
                w_tx_nxt   = 1'b0;
                w_baud_nxt = r_baud + c_CNT_ONE;
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = c_ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end

            c_ST_DATA: begin
                w_tx_nxt   = r_shift[0];
                w_baud_nxt = r_baud + c_CNT_ONE;
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        if (c_PAR_EN) begin
                            w_state_nxt = c_ST_PARITY;
                            w_tx_nxt    = r_parity;
                        end else begin
                            w_state_nxt = c_ST_STOP;
                            w_stop_nxt  = 1'b0;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                        w_tx_nxt  = r_shift[1];
                    end
                end
            end

            c_ST_PARITY: begin
                w_tx_nxt   = r_parity;
                w_baud_nxt = r_baud + c_CNT_ONE;
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_stop_nxt  = 1'b0;
                    w_state_nxt = c_ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end

            c_ST_STOP: begin
                w_baud_nxt = r_baud + c_CNT_ONE;
                // Raised one cycle early so the registered pulse lands on the final stop cycle.
                w_done_nxt = w_last_stop && (r_baud == c_CNT_PRE);
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (w_last_stop) begin
                        w_state_nxt = c_ST_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_stop_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign fifo_rd   = r_rd;
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign byte_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// Bench for fifo_uart_tx: three instances (8N1, 8E1, 8E2) against a frame-level model.
module tb_fifo_uart_tx;

    localparam int C  = 4;
    localparam int NI = 3;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic [2:0] fifo_empty;
    logic [2:0] fifo_rd;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] byte_done;
    logic [7:0] fifo_data [NI];

    always #5 clock = ~clock;

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clock(clock), .rst(rst), .en(en), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
        .fifo_rd(fifo_rd[0]), .tx(tx[0]), .busy(busy[0]), .byte_done(byte_done[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
        .clock(clock), .rst(rst), .en(en), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
        .fifo_rd(fifo_rd[1]), .tx(tx[1]), .busy(busy[1]), .byte_done(byte_done[1]));
    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .STOP_BITS(2)) dut2 (
        .clock(clock), .rst(rst), .en(en), .fifo_empty(fifo_empty[2]), .fifo_data(fifo_data[2]),
        .fifo_rd(fifo_rd[2]), .tx(tx[2]), .busy(busy[2]), .byte_done(byte_done[2]));

    // FIFO storage shared by the bench FIFO (frd) and the expectation model (erd).
    logic [7:0] fmem [NI][64];
    int fwr [NI] = '{0, 0, 0};
    int frd [NI] = '{0, 0, 0};
    int erd [NI] = '{0, 0, 0};
    logic [2:0] rd_s;

    for (genvar g = 0; g < NI; g++) begin : g_fifo
        assign fifo_empty[g] = (frd[g] == fwr[g]);
    end

    always @(posedge clock) begin
        rd_s = fifo_rd;
        #1;
        for (int k = 0; k < NI; k++) begin
            if (rd_s[k] === 1'b1 && frd[k] != fwr[k]) begin
                fifo_data[k] = fmem[k][frd[k]];
                frd[k] = frd[k] + 1;
            end
        end
    end

    task automatic push(input int k, input logic [7:0] b);
        fmem[k][fwr[k]] = b;
        fwr[k] = fwr[k] + 1;
    endtask

    function automatic int par_of(input int k);
        return (k != 0) ? 1 : 0;
    endfunction

    function automatic int frame_len(input int k);
        return (9 + par_of(k) + ((k == 2) ? 2 : 1)) * C;
    endfunction

    // Frame-level model: m_pos counts cycles since the POP cycle began.
    bit         m_idle [NI];
    int         m_pos  [NI];
    logic [7:0] m_byte [NI];

    always @(posedge clock) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_idle[k] = 1'b1;
            end else if (m_idle[k]) begin
                if (en && erd[k] != fwr[k]) begin
                    m_byte[k] = fmem[k][erd[k]];
                    erd[k]    = erd[k] + 1;
                    m_idle[k] = 1'b0;
                    m_pos[k]  = 0;
                end
            end else begin
                m_pos[k] = m_pos[k] + 1;
                if (m_pos[k] == 2 + frame_len(k)) m_idle[k] = 1'b1;
            end
        end
    end

    function automatic logic [3:0] expect_out(input int k);
        int   idx;
        logic b;
        if (m_idle[k]) return 4'b0100;
        if (m_pos[k] < 2) begin
            b = 1'b1;
        end else begin
            idx = (m_pos[k] - 2) / C;
            if (idx == 0)                        b = 1'b0;
            else if (idx <= 8)                   b = m_byte[k][idx-1];
            else if (par_of(k) == 1 && idx == 9) b = ^m_byte[k];
            else                                 b = 1'b1;
        end
        return {(m_pos[k] == 0), b, 1'b1, (m_pos[k] == 2 + frame_len(k) - 1)};
    endfunction

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                logic [3:0] got;
                logic [3:0] exp;
                got = {fifo_rd[k], tx[k], busy[k], byte_done[k]};
                exp = expect_out(k);
                checks = checks + 1;
                if (got !== exp) begin
                    errors = errors + 1;
                    $display("FAIL model[%0d] t=%0t rd/tx/busy/done got %b required %b", k, $time, got, exp);
                end
            end
        end
    end

    // Frame monitor: pulse counts, frame length, mid-bit samples and idle gap.
    int         rd_cnt   [NI] = '{0, 0, 0};
    int         done_cnt [NI] = '{0, 0, 0};
    int         flen_m   [NI] = '{0, 0, 0};
    int         gap_m    [NI] = '{0, 0, 0};
    int         gap_cur  [NI] = '{0, 0, 0};
    int         len_cur  [NI] = '{0, 0, 0};
    bit         in_fr    [NI] = '{0, 0, 0};
    logic [11:0] bits_cur [NI];
    logic [11:0] bits_m   [NI];

    always @(negedge clock) begin
        for (int k = 0; k < NI; k++) begin
            if (fifo_rd[k] === 1'b1)   rd_cnt[k]   = rd_cnt[k] + 1;
            if (byte_done[k] === 1'b1) done_cnt[k] = done_cnt[k] + 1;
            if (busy[k] !== 1'b1) in_fr[k] = 1'b0;
            if (!in_fr[k] && busy[k] === 1'b1 && tx[k] === 1'b0) begin
                in_fr[k]    = 1'b1;
                len_cur[k]  = 0;
                bits_cur[k] = '0;
                gap_m[k]    = gap_cur[k];
            end
            if (in_fr[k]) begin
                if (len_cur[k] % C == C / 2 && len_cur[k] / C < 12)
                    bits_cur[k][len_cur[k] / C] = tx[k];
                len_cur[k] = len_cur[k] + 1;
                if (byte_done[k] === 1'b1) begin
                    flen_m[k]  = len_cur[k];
                    bits_m[k]  = bits_cur[k];
                    in_fr[k]   = 1'b0;
                    gap_cur[k] = 0;
                end
            end else begin
                gap_cur[k] = gap_cur[k] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    initial begin
        cyc(3);
        chk_en = 1'b1;
        check("reset_tx",   {29'd0, tx},        32'h7);
        check("reset_busy", {29'd0, busy},      32'h0);
        check("reset_rd",   {29'd0, fifo_rd},   32'h0);
        check("reset_done", {29'd0, byte_done}, 32'h0);
        rst = 1'b0;

        // Single byte 0xA5 on every configuration
        for (int k = 0; k < NI; k++) push(k, 8'hA5);
        en = 1'b1;
        cyc(70);
        check("a5_rd_pulses",  rd_cnt[0],        1);
        check("a5_done_cnt",   done_cnt[0],      1);
        check("a5_len_8n1",    flen_m[0],        40);
        check("a5_bits_8n1",   bits_m[0][9:0],   32'h34A);
        check("a5_len_8e1",    flen_m[1],        44);
        check("a5_parity_8e1", bits_m[1][9],     0);
        check("a5_len_8e2",    flen_m[2],        48);

        // Three back-to-back bytes
        push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
        cyc(140);
        check("b2b_rd_pulses", rd_cnt[0],      4);
        check("b2b_done_cnt",  done_cnt[0],    4);
        check("b2b_gap",       gap_m[0],       3);
        check("b2b_last_byte", bits_m[0][8:1], 8'h03);
        check("b2b_busy",      busy[0],        0);

        // Parity: 0x07 -> 1, 0x03 -> 0
        push(1, 8'h07); push(2, 8'h07);
        cyc(70);
        check("p07_bit_8e1",  bits_m[1][9],     1);
        check("p07_bit_8e2",  bits_m[2][9],     1);
        check("p07_stop_8e2", bits_m[2][11:10], 2'b11);
        check("p07_len_8e2",  flen_m[2],        48);
        push(1, 8'h03); push(2, 8'h03);
        cyc(70);
        check("p03_bit_8e1",  bits_m[1][9],   0);
        check("p03_bit_8e2",  bits_m[2][9],   0);
        check("p03_data_8e1", bits_m[1][8:1], 8'h03);
        check("p03_len_8e1",  flen_m[1],      44);

        // en low with data waiting, then en dropped mid-DATA
        en = 1'b0;
        for (int k = 0; k < NI; k++) push(k, 8'h5A);
        cyc(60);
        check("en0_no_rd", rd_cnt[0], 4);
        check("en0_tx",    {29'd0, tx}, 32'h7);
        en = 1'b1;
        cyc(20);
        en = 1'b0;
        for (int k = 0; k < NI; k++) push(k, 8'h3C);
        cyc(80);
        check("endrop_rd",   rd_cnt[0],      5);
        check("endrop_done", done_cnt[0],    5);
        check("endrop_byte", bits_m[0][8:1], 8'h5A);

        // Reset during data bit 4, then a clean frame
        en = 1'b1;
        cyc(24);
        rst = 1'b1;
        cyc(1);
        check("rst_tx",   {29'd0, tx},      32'h7);
        check("rst_busy", {29'd0, busy},    32'h0);
        check("rst_rd",   {29'd0, fifo_rd}, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < NI; k++) push(k, 8'h81);
        cyc(70);
        check("post_rst_bits", bits_m[0][9:0], 32'h302);
        check("post_rst_done", done_cnt[0],    6);
        check("post_rst_rd",   rd_cnt[0],      7);

        // Empty FIFO with en high
        cyc(100);
        check("empty_rd",   rd_cnt[0],          7);
        check("empty_busy", {29'd0, busy},      32'h0);
        check("empty_tx",   {29'd0, tx},        32'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
